// File: rtl/fetch_pkg.sv
// Shared types for the fetch queue: PC/instruction words, FSM encoding and queue entry layout.
package fetch_pkg;

   localparam int PC_W   = 32;
   localparam int INST_W = 32;

   typedef logic [PC_W-1:0]   pc_t;
   typedef logic [INST_W-1:0] inst_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      STALE = 2'd2
   } fq_state_e;

   typedef struct packed {
      pc_t   pc;
      inst_t inst;
   } fq_entry_t;

endpackage

// File: rtl/fetch_queue_ctrl_if.sv
// I-cache fetch port, branch predict/resolve inputs and decode-side outputs of the fetch queue.
interface fetch_queue_ctrl_if #(
   parameter int FETCH_WIDTH  = 2,
   parameter int DECODE_WIDTH = 2,
   parameter int DEPTH        = 8,
   parameter int XLEN         = 32
);
   localparam int LANE_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
   localparam int ACC_W  = $clog2(DECODE_WIDTH + 1);
   localparam int CNT_W  = $clog2(DEPTH + 1);

   logic                         fetch_req_valid;
   logic [XLEN-1:0]              fetch_req_pc;
   logic                         fetch_req_ready;
   logic                         fetch_rsp_valid;
   logic [FETCH_WIDTH*32-1:0]    fetch_rsp_data;
   logic                         predict_valid;
   logic [LANE_W-1:0]            predict_lane;
   logic [XLEN-1:0]              predict_dst;
   logic                         resolve_valid;
   logic                         resolve_mispredict;
   logic [XLEN-1:0]              resolve_dst;
   logic [DECODE_WIDTH-1:0]      decode_valid;
   logic [DECODE_WIDTH*32-1:0]   decode_inst;
   logic [DECODE_WIDTH*XLEN-1:0] decode_pc;
   logic [ACC_W-1:0]             decode_accept;
   logic [CNT_W-1:0]             count;

   modport master (
      output fetch_req_valid, fetch_req_pc,
      input  fetch_req_ready, fetch_rsp_valid, fetch_rsp_data,
      input  predict_valid, predict_lane, predict_dst,
      input  resolve_valid, resolve_mispredict, resolve_dst,
      output decode_valid, decode_inst, decode_pc,
      input  decode_accept,
      output count
   );

   modport slave (
      input  fetch_req_valid, fetch_req_pc,
      output fetch_req_ready, fetch_rsp_valid, fetch_rsp_data,
      output predict_valid, predict_lane, predict_dst,
      output resolve_valid, resolve_mispredict, resolve_dst,
      input  decode_valid, decode_inst, decode_pc,
      output decode_accept,
      input  count
   );

endinterface

// File: rtl/fetch_ring.sv
// Circular instruction buffer: up to PUSH_N writes and POP_N reads per cycle, flush, occupancy count.
module fetch_ring
   import fetch_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int PUSH_N = 2,
   parameter int POP_N  = 2
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             flush_i,
   input  logic [$clog2(PUSH_N+1)-1:0]      push_cnt_i,
   input  fq_entry_t                        push_data_i [PUSH_N],
   input  logic [$clog2(POP_N+1)-1:0]       pop_cnt_i,
   output fq_entry_t                        head_data_o [POP_N],
   output logic [POP_N-1:0]                 head_valid_o,
   output logic [$clog2(DEPTH+1)-1:0]       count_o
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   fq_entry_t        mem_q [DEPTH];
   logic [IDX_W-1:0] head_q, head_d;
   logic [IDX_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Indices wrap naturally; count alone tells full from empty.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush_i) begin
         tail_d  = head_q;
         count_d = '0;
      end else begin
         head_d  = head_q + IDX_W'(pop_cnt_i);
         tail_d  = tail_q + IDX_W'(push_cnt_i);
         count_d = count_q - CNT_W'(pop_cnt_i) + CNT_W'(push_cnt_i);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      for (int i = 0; i < PUSH_N; i++) begin
         if (!flush_i && i < int'(push_cnt_i))
            mem_q[tail_q + IDX_W'(i)] <= push_data_i[i];
      end
   end

   // Invalid lanes read as zero so stale storage never reaches decode.
   always_comb begin
      for (int i = 0; i < POP_N; i++) begin
         head_valid_o[i] = i < int'(count_q);
         head_data_o[i]  = head_valid_o[i] ? mem_q[head_q + IDX_W'(i)] : '0;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/fetch_queue_ctrl.sv
// Fetch PC generation, single-outstanding I-fetch FSM and mispredict redirect in front of a fetch_ring.
// Optional FETCH_QUEUE_PERF_EN adds saturating flush and starvation counters.
module fetch_queue_ctrl
   import fetch_pkg::*;
#(
   parameter int              FETCH_WIDTH  = 2,
   parameter int              DECODE_WIDTH = 2,
   parameter int              DEPTH        = 8,
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_PC     = '0
) (
   input  logic               clock,
   input  logic               reset,
   fetch_queue_ctrl_if.master bus
`ifdef FETCH_QUEUE_PERF_EN
   ,
   output logic [31:0]        perf_flush,
   output logic [31:0]        perf_starve
`endif
);
   localparam int              PUSH_W      = $clog2(FETCH_WIDTH + 1);
   localparam int              CNT_W       = $clog2(DEPTH + 1);
   localparam logic [1:0]      ST_IDLE     = IDLE;
   localparam logic [1:0]      ST_WAIT     = WAIT;
   localparam logic [1:0]      ST_STALE    = STALE;
   localparam logic [XLEN-1:0] FETCH_BYTES = XLEN'(4 * FETCH_WIDTH);

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
      return a & ~XLEN'(3);
   endfunction

   logic [1:0]        state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [CNT_W-1:0]  count;
   logic              flush, req_ok, handshake, rsp_push;
   logic [PUSH_W-1:0] push_cnt;
   fq_entry_t         push_data [FETCH_WIDTH];
   fq_entry_t         head_data [DECODE_WIDTH];
   logic [DECODE_WIDTH-1:0] head_valid;

   assign flush     = bus.resolve_valid & bus.resolve_mispredict;
   // Space check uses pre-pop occupancy; gating with reset keeps the request low while held in reset.
   assign req_ok    = reset && (state_q == ST_IDLE) &&
                      ((CNT_W'(DEPTH) - count) >= CNT_W'(FETCH_WIDTH));
   assign handshake = req_ok & bus.fetch_req_ready;
   assign rsp_push  = (state_q == ST_WAIT) & bus.fetch_rsp_valid;

   always_comb begin
      push_cnt = '0;
      if (rsp_push)
         push_cnt = bus.predict_valid ? PUSH_W'(bus.predict_lane) + PUSH_W'(1)
                                      : PUSH_W'(FETCH_WIDTH);
   end

   for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_push
      assign push_data[i] = {pc_t'(pc_q + XLEN'(4 * i)), bus.fetch_rsp_data[32*i +: 32]};
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      case (state_q)
         ST_IDLE:  if (handshake) state_d = ST_WAIT;
         ST_WAIT:  if (bus.fetch_rsp_valid) begin
                      state_d = ST_IDLE;
                      pc_d    = bus.predict_valid ? word_align(bus.predict_dst) : pc_q + FETCH_BYTES;
                   end
         ST_STALE: if (bus.fetch_rsp_valid) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      // A response still owed to the old path must be swallowed before fetching the new one.
      if (flush) begin
         pc_d    = word_align(bus.resolve_dst);
         state_d = ((state_q == ST_WAIT && !bus.fetch_rsp_valid) || handshake) ? ST_STALE : ST_IDLE;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         pc_q    <= word_align(RESET_PC);
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   fetch_ring #(
      .DEPTH  (DEPTH),
      .PUSH_N (FETCH_WIDTH),
      .POP_N  (DECODE_WIDTH)
   ) u_ring (
      .clock        (clock),
      .reset        (reset),
      .flush_i      (flush),
      .push_cnt_i   (push_cnt),
      .push_data_i  (push_data),
      .pop_cnt_i    (bus.decode_accept),
      .head_data_o  (head_data),
      .head_valid_o (head_valid),
      .count_o      (count)
   );

   assign bus.fetch_req_valid = req_ok;
   assign bus.fetch_req_pc    = pc_q;
   assign bus.decode_valid    = head_valid;
   assign bus.count           = count;

   for (genvar j = 0; j < DECODE_WIDTH; j++) begin : g_dec
      assign bus.decode_inst[32*j +: 32]    = head_data[j].inst;
      assign bus.decode_pc[XLEN*j +: XLEN] = XLEN'(head_data[j].pc);
   end

`ifdef FETCH_QUEUE_PERF_EN
   logic [31:0] perf_flush_q, perf_starve_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         perf_flush_q  <= '0;
         perf_starve_q <= '0;
      end else begin
         if (flush && !(&perf_flush_q))         perf_flush_q  <= perf_flush_q + 32'd1;
         if (count == '0 && !(&perf_starve_q))  perf_starve_q <= perf_starve_q + 32'd1;
      end
   end

   assign perf_flush  = perf_flush_q;
   assign perf_starve = perf_starve_q;
`endif

`ifndef SYNTHESIS
   always @(posedge clock) begin
      if (reset) begin
         assert (!(state_q == ST_IDLE && bus.fetch_rsp_valid));
         assert (int'(bus.decode_accept) <= int'(count) && int'(bus.decode_accept) <= DECODE_WIDTH);
      end
   end
`endif

endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// Scoreboard bench for fetch_queue_ctrl: I-cache responder model, expected decode entries queued at push time.
module tb_fetch_queue_ctrl;
   localparam int FW    = 2;
   localparam int DW    = 2;
   localparam int DEPTH = 8;
   localparam int XLEN  = 32;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   fetch_queue_ctrl_if #(.FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .DEPTH(DEPTH), .XLEN(XLEN)) bus ();

`ifdef FETCH_QUEUE_PERF_EN
   logic [31:0] perf_flush, perf_starve;
`endif

   fetch_queue_ctrl #(
      .FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .DEPTH(DEPTH), .XLEN(XLEN), .RESET_PC(32'h0)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
`ifdef FETCH_QUEUE_PERF_EN
      ,
      .perf_flush  (perf_flush),
      .perf_starve (perf_starve)
`endif
   );

   int          n_checks;
   int          n_fail;
   logic [31:0] exp_pc;
   logic [31:0] q_pc[$];
   logic [31:0] q_inst[$];

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return pc ^ 32'h5EED_C0DE;
   endfunction

   function automatic logic [1:0] exp_valid(input int sz);
      return (sz >= 2) ? 2'b11 : ((sz == 1) ? 2'b01 : 2'b00);
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      bus.fetch_req_ready    = 1'b0;
      bus.fetch_rsp_valid    = 1'b0;
      bus.fetch_rsp_data     = '0;
      bus.predict_valid      = 1'b0;
      bus.predict_lane       = '0;
      bus.predict_dst        = '0;
      bus.resolve_valid      = 1'b0;
      bus.resolve_mispredict = 1'b0;
      bus.resolve_dst        = '0;
      bus.decode_accept      = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      tick();
      q_pc.delete();
      q_inst.delete();
      exp_pc = 32'h0;
   endtask

   task automatic check_head(input int n);
      for (int i = 0; i < n; i++) begin
         check_eq("dec_pc", bus.decode_pc[32*i +: 32], q_pc[i]);
         check_eq("dec_inst", bus.decode_inst[32*i +: 32], q_inst[i]);
      end
   endtask

   task automatic pop_entries(input int n);
      repeat (n) begin
         void'(q_pc.pop_front());
         void'(q_inst.pop_front());
      end
   endtask

   task automatic pop_cycle(input int n);
      check_eq("dec_valid", bus.decode_valid, exp_valid(q_pc.size()));
      check_head(n);
      bus.decode_accept = 2'(n);
      tick();
      bus.decode_accept = '0;
      pop_entries(n);
      check_eq("count_pop", bus.count, q_pc.size());
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (q_pc.size() > 0 && guard < 20) begin
         pop_cycle((q_pc.size() >= 2) ? 2 : 1);
         guard++;
      end
      check_eq("drained", bus.count, 0);
   endtask

   task automatic wait_req();
      int n;
      n = 0;
      while (!bus.fetch_req_valid && n < 20) begin
         tick();
         n++;
      end
      check_eq("req_seen", n < 20, 1'b1);
      check_eq("req_pc", bus.fetch_req_pc, exp_pc);
   endtask

   task automatic fetch_once(input bit pv, input logic lane, input logic [31:0] dst, input int acc);
      logic [31:0] pc;
      int          npush;
      wait_req();
      bus.fetch_req_ready = 1'b1;
      tick();
      bus.fetch_req_ready = 1'b0;
      check_eq("req_lo_wait", bus.fetch_req_valid, 1'b0);
      if (acc > 0) begin
         check_head(acc);
         bus.decode_accept = 2'(acc);
      end
      pc = exp_pc;
      bus.fetch_rsp_valid = 1'b1;
      for (int i = 0; i < FW; i++) bus.fetch_rsp_data[32*i +: 32] = inst_of(pc + 32'(4*i));
      bus.predict_valid = pv;
      bus.predict_lane  = lane;
      bus.predict_dst   = dst;
      tick();
      idle_inputs();
      pop_entries(acc);
      npush = pv ? int'(lane) + 1 : FW;
      for (int i = 0; i < npush; i++) begin
         q_pc.push_back(pc + 32'(4*i));
         q_inst.push_back(inst_of(pc + 32'(4*i)));
      end
      exp_pc = pv ? {dst[31:2], 2'b00} : pc + 32'(4*FW);
      check_eq("count_push", bus.count, q_pc.size());
   endtask

   task automatic stream_test();
      int          nreq, popped, cyc, sz, acc;
      bit          rsp_due;
      logic [31:0] last_pc;
      nreq = 0; popped = 0; cyc = 0; rsp_due = 1'b0; last_pc = '0;
      while (popped < 40 && cyc < 400) begin
         sz  = q_pc.size();
         acc = (sz >= 2) ? 2 : sz;
         check_eq("st_valid", bus.decode_valid, exp_valid(sz));
         check_head(acc);
         if (acc > 0) last_pc = bus.decode_pc[32*(acc-1) +: 32];
         bus.decode_accept = 2'(acc);
         pop_entries(acc);
         popped += acc;
         if (rsp_due) begin
            bus.fetch_rsp_valid = 1'b1;
            for (int i = 0; i < FW; i++) begin
               bus.fetch_rsp_data[32*i +: 32] = inst_of(exp_pc + 32'(4*i));
               q_pc.push_back(exp_pc + 32'(4*i));
               q_inst.push_back(inst_of(exp_pc + 32'(4*i)));
            end
            exp_pc  = exp_pc + 32'(4*FW);
            rsp_due = 1'b0;
         end else begin
            bus.fetch_rsp_valid = 1'b0;
         end
         if (bus.fetch_req_valid && nreq < 20) begin
            check_eq("st_req_pc", bus.fetch_req_pc, exp_pc);
            bus.fetch_req_ready = 1'b1;
            nreq++;
            rsp_due = 1'b1;
         end else begin
            bus.fetch_req_ready = 1'b0;
         end
         tick();
         cyc++;
      end
      idle_inputs();
      check_eq("st_popped", popped, 40);
      check_eq("st_last_pc", last_pc, 32'h9C);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      exp_pc   = 32'h0;
      idle_inputs();
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check_eq("rst_req_valid", bus.fetch_req_valid, 1'b0);
      check_eq("rst_req_pc", bus.fetch_req_pc, 32'h0);
      check_eq("rst_dec_valid", bus.decode_valid, 2'b00);
      check_eq("rst_count", bus.count, 0);
      check_eq("rst_dec_pc", bus.decode_pc, 64'h0);
      check_eq("rst_dec_inst", bus.decode_inst, 64'h0);
      @(negedge clock);
      reset = 1'b1;
      tick();

      // Fill to DEPTH with back-to-back fetches, then confirm requests stop.
      for (int k = 0; k < 4; k++) fetch_once(1'b0, 1'b0, 32'h0, 0);
      check_eq("full_count", bus.count, 8);
      repeat (3) begin
         check_eq("full_no_req", bus.fetch_req_valid, 1'b0);
         tick();
      end
      drain();

      // Taken prediction in lane 0 truncates the group and redirects.
      do_reset();
      fetch_once(1'b1, 1'b0, 32'h100, 0);
      check_eq("pred_count", bus.count, 1);
      drain();

      // Mispredict while a fetch is in flight: flush, discard stale response, refetch at aligned dst.
      fetch_once(1'b0, 1'b0, 32'h0, 0);
      wait_req();
      bus.fetch_req_ready = 1'b1;
      tick();
      bus.fetch_req_ready    = 1'b0;
      bus.resolve_valid      = 1'b1;
      bus.resolve_mispredict = 1'b1;
      bus.resolve_dst        = 32'h203;
      tick();
      idle_inputs();
      q_pc.delete();
      q_inst.delete();
      exp_pc = 32'h200;
      check_eq("flush_count", bus.count, 0);
      check_eq("flush_dec_valid", bus.decode_valid, 2'b00);
      check_eq("stale_no_req", bus.fetch_req_valid, 1'b0);
      bus.fetch_rsp_valid = 1'b1;
      bus.fetch_rsp_data  = 64'hFFFF_FFFF_FFFF_FFFF;
      bus.predict_valid   = 1'b1;
      bus.predict_dst     = 32'h400;
      tick();
      idle_inputs();
      check_eq("stale_count", bus.count, 0);
      check_eq("stale_req_valid", bus.fetch_req_valid, 1'b1);
      fetch_once(1'b0, 1'b0, 32'h0, 0);
      drain();

      // Simultaneous single pop and 2-lane push at count 3.
      begin
         logic [31:0] head_before;
         fetch_once(1'b0, 1'b0, 32'h0, 0);
         fetch_once(1'b0, 1'b0, 32'h0, 0);
         pop_cycle(1);
         check_eq("pre_count3", bus.count, 3);
         head_before = q_pc[0];
         fetch_once(1'b0, 1'b0, 32'h0, 1);
         check_eq("pushpop_count", bus.count, 4);
         check_eq("pc_adv4", bus.decode_pc[31:0], head_before + 32'd4);
      end

      // Asynchronous reset between edges while a fetch is outstanding.
      wait_req();
      bus.fetch_req_ready = 1'b1;
      tick();
      bus.fetch_req_ready = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      check_eq("arst_req_valid", bus.fetch_req_valid, 1'b0);
      check_eq("arst_dec_valid", bus.decode_valid, 2'b00);
      check_eq("arst_count", bus.count, 0);
      check_eq("arst_req_pc", bus.fetch_req_pc, 32'h0);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      tick();
      q_pc.delete();
      q_inst.delete();
      exp_pc = 32'h0;
      fetch_once(1'b0, 1'b0, 32'h0, 0);
      drain();

      // Continuous streaming across several index wraps.
      do_reset();
      stream_test();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
